// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display scan path.
//   bcd_t        : one BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD value; anything above is blanked
//   AN_OFF       : level of an inactive (dark) anode line
//   scan_state_t : per-slot phase, dark guard (GAP) or lit (DRIVE)
//   bcd_invalid  : true for a nibble that is not a legal BCD digit
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam logic AN_OFF  = 1'b1;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    function automatic logic bcd_invalid(input bcd_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-timing counter for the display scanner. Counts 0..PRESCALE-1 and
// wraps.
//   clk, rst : system clock, synchronous active-high reset
//   slot_end : counter is at PRESCALE-1 (last cycle of a slot)
//   gap_end  : counter is at GUARD-1 (last dark cycle of a slot)
//   in_gap   : counter is below GUARD (dark guard interval)
module scan_prescaler #(
    parameter int PRESCALE = 100000,
    parameter int GUARD    = 2
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic gap_end,
    output logic in_gap
);

    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;

    assign slot_end = (pc_reg == PC_W'(PRESCALE - 1));
    assign gap_end  = (pc_reg == PC_W'(GUARD - 1));
    assign in_gap   = (pc_reg <  PC_W'(GUARD));

    always_comb begin
        pc_next = pc_reg + PC_W'(1);
        if (slot_end) begin
            pc_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display. A packed BCD word is taken over valid/ready into a
// shadow buffer and copied to the displayed (active) buffer only on the
// frame wrap, so a frame never shows a mix of two words.
//   clk, rst     : system clock, synchronous active-high reset
//   in_valid     : producer offers digits_in
//   in_ready     : shadow buffer is free
//   digits_in    : packed BCD, nibble 0 is the rightmost digit
//   an           : active-low anode enables (registered)
//   cur_digit    : nibble of the current slot, to the segment decoder
//   blank        : cur_digit is not a legal BCD digit
//   slot         : current digit slot
//   frame_tick   : last cycle of the last slot of a frame
//   invalid_seen : displayed word holds at least one non-BCD nibble
module display_scan_controller
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 100000,
    parameter int GUARD    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DIGITS-1:0]       digits_in,
    output logic [DIGITS-1:0]         an,
    output logic [3:0]                cur_digit,
    output logic                      blank,
    output logic [$clog2(DIGITS)-1:0] slot,
    output logic                      frame_tick,
    output logic                      invalid_seen
);

    localparam int SLOT_W = $clog2(DIGITS);

    logic slot_end;
    logic gap_end;
    logic in_gap;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .gap_end  (gap_end),
        .in_gap   (in_gap)
    );

    logic [4*DIGITS-1:0] shadow_reg,  shadow_next;
    logic                pending_reg, pending_next;
    logic [4*DIGITS-1:0] active_reg,  active_next;
    logic                invalid_reg, invalid_next;
    logic [SLOT_W-1:0]   slot_reg,    slot_next;
    logic [DIGITS-1:0]   an_reg,      an_next;
    scan_state_t         state_reg,   state_next;

    bcd_t              active_nib [DIGITS];
    logic [DIGITS-1:0] shadow_bad;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign active_nib[gi] = active_reg[4*gi +: 4];
            assign shadow_bad[gi] = bcd_invalid(shadow_reg[4*gi +: 4]);
        end
    endgenerate

    logic wrap;
    logic accept;
    logic commit;

    assign wrap   = slot_end && (slot_reg == SLOT_W'(DIGITS - 1));
    assign accept = in_valid && !pending_reg;
    // Commit and accept are mutually exclusive: one needs pending set,
    // the other needs it clear. A word accepted on the wrap waits a frame.
    assign commit = wrap && pending_reg;

    always_comb begin
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        active_next  = active_reg;
        invalid_next = invalid_reg;
        slot_next    = slot_reg;

        if (accept) begin
            shadow_next  = digits_in;
            pending_next = 1'b1;
        end
        if (commit) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
            invalid_next = |shadow_bad;
        end
        if (slot_end) begin
            slot_next = wrap ? '0 : slot_reg + SLOT_W'(1);
        end
    end

    // Slot phase: dark for the first GUARD cycles, then lit until the slot
    // ends. The anode pattern is computed from the next state so the
    // registered an lines up with the counter value it belongs to.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_GAP: begin
                if (gap_end) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // in_gap here would mean the phase lost track of the
                // counter; going dark is the safe recovery.
                if (slot_end || in_gap) begin
                    state_next = ST_GAP;
                end
            end
            default: state_next = ST_GAP;
        endcase

        an_next = {DIGITS{AN_OFF}};
        if (state_next == ST_DRIVE) begin
            an_next = ~(DIGITS'(1) << slot_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
            active_reg  <= {DIGITS{4'hF}};
            invalid_reg <= 1'b1;
            slot_reg    <= '0;
            an_reg      <= {DIGITS{AN_OFF}};
            state_reg   <= ST_GAP;
        end else begin
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            active_reg  <= active_next;
            invalid_reg <= invalid_next;
            slot_reg    <= slot_next;
            an_reg      <= an_next;
            state_reg   <= state_next;
        end
    end

    assign in_ready     = !pending_reg;
    assign an           = an_reg;
    assign cur_digit    = active_nib[slot_reg];
    assign blank        = bcd_invalid(cur_digit);
    assign slot         = slot_reg;
    assign frame_tick   = wrap;
    assign invalid_seen = invalid_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIGITS=4, PRESCALE=8,
// GUARD=2. cyc counts cycles since the last reset release; a slot lasts
// 8 cycles and a frame 32, so slot s of the frame starting at cycle b is
// mid-DRIVE at cycle b+8*s+4.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] digits_in;
    logic [3:0]  an;
    logic [3:0]  cur_digit;
    logic        blank;
    logic [1:0]  slot;
    logic        frame_tick;
    logic        invalid_seen;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    display_scan_controller #(
        .DIGITS   (4),
        .PRESCALE (8),
        .GUARD    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .digits_in    (digits_in),
        .an           (an),
        .cur_digit    (cur_digit),
        .blank        (blank),
        .slot         (slot),
        .frame_tick   (frame_tick),
        .invalid_seen (invalid_seen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected anodes: dark for the first two cycles of each slot.
    function automatic logic [3:0] an_model(input int c);
        int pc;
        int s;
        pc = c % 8;
        s  = (c / 8) % 4;
        if (pc < 2) return 4'hF;
        return ~(4'(1) << s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            check("an", 32'(an), 32'(an_model(cyc)));
            check("frame_tick", 32'(frame_tick), 32'(cyc % 32 == 31));
            check("slot", 32'(slot), 32'((cyc / 8) % 4));
        end
    endtask

    task automatic goto(input int target);
        if (cyc > target) begin
            check("goto_overrun", 32'(cyc), 32'(target));
        end
        while (cyc < target) step();
    endtask

    // Check the digit and blank flag in the middle of every slot of a frame.
    task automatic show_frame(input int base, input logic [15:0] word);
        logic [3:0] nib;
        for (int s = 0; s < 4; s++) begin
            goto(base + 8 * s + 4);
            nib = word[4*s +: 4];
            check($sformatf("cur_digit_s%0d", s), 32'(cur_digit), 32'(nib));
            check($sformatf("blank_s%0d", s), 32'(blank), 32'(nib > 4'd9));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_slot"}, 32'(slot), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_cur_digit"}, 32'(cur_digit), 32'hF);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        check({tag, "_invalid_seen"}, 32'(invalid_seen), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        digits_in = 16'h0000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 0;
        mon_en = 1'b1;

        // Reset release, no input: dark frame of blanked digits.
        check_reset_state("reset");
        step();
        check("an_gap1", 32'(an), 32'hF);
        step();
        check("an_drive0", 32'(an), 32'hE);
        show_frame(0, 16'hFFFF);
        check("invalid_idle", 32'(invalid_seen), 32'd1);

        // Accept 1234 during slot 1 of frame 32; commits at wrap 63.
        goto(43);
        check("ready_before_1234", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        digits_in = 16'h1234;
        $display("accept %h at cyc %0d", digits_in, cyc);
        step();
        in_valid = 1'b0;
        check("ready_low_1234", 32'(in_ready), 32'd0);
        goto(48);
        check("old_frame_blank", 32'(blank), 32'd1);
        goto(64);
        check("ready_back_1234", 32'(in_ready), 32'd1);
        check("invalid_1234", 32'(invalid_seen), 32'd0);
        show_frame(64, 16'h1234);

        // Accept 9A09: slot 2 holds A and is blanked.
        goto(98);
        in_valid  = 1'b1;
        digits_in = 16'h9A09;
        $display("accept %h at cyc %0d", digits_in, cyc);
        step();
        in_valid = 1'b0;
        goto(127);
        check("invalid_pre_9A09", 32'(invalid_seen), 32'd0);
        goto(128);
        check("invalid_9A09", 32'(invalid_seen), 32'd1);
        show_frame(128, 16'h9A09);

        // Continuous valid with changing data while pending.
        goto(161);
        check("ready_before_5678", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        digits_in = 16'h5678;
        $display("accept %h at cyc %0d", digits_in, cyc);
        step();
        while (cyc < 192) begin
            check("ready_held_low", 32'(in_ready), 32'd0);
            digits_in = 16'h9000 + 16'(cyc);
            step();
        end
        in_valid = 1'b0;
        check("ready_after_wrap", 32'(in_ready), 32'd1);
        check("invalid_5678", 32'(invalid_seen), 32'd0);
        show_frame(192, 16'h5678);

        // Accept exactly on the wrap cycle with nothing pending.
        goto(223);
        in_valid  = 1'b1;
        digits_in = 16'h4321;
        $display("accept %h at cyc %0d (wrap)", digits_in, cyc);
        step();
        in_valid = 1'b0;
        check("ready_low_4321", 32'(in_ready), 32'd0);
        show_frame(224, 16'h5678);
        goto(256);
        check("ready_back_4321", 32'(in_ready), 32'd1);
        show_frame(256, 16'h4321);

        // Reset mid-DRIVE of slot 2 with a word pending.
        goto(289);
        in_valid  = 1'b1;
        digits_in = 16'h8888;
        $display("accept %h at cyc %0d", digits_in, cyc);
        step();
        in_valid = 1'b0;
        check("ready_low_8888", 32'(in_ready), 32'd0);
        goto(308);
        check("slot_before_rst", 32'(slot), 32'd2);
        mon_en = 1'b0;
        rst    = 1'b1;
        $display("reset pulse at cyc %0d", cyc);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        check_reset_state("midrst");
        mon_en = 1'b1;
        show_frame(0, 16'hFFFF);
        show_frame(32, 16'hFFFF);
        check("invalid_after_rst", 32'(invalid_seen), 32'd1);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It accepts a packed BCD word through a valid/ready handshake and double-buffers it, committing new data only at frame boundaries so no frame is torn. Each refresh slot selects one digit onto the shared BCD-to-segment decoder path, with a dark guard interval between slots. Any digit greater than 9 is flagged for blanking.

## Interface
- `DIGITS`, 4: number of digit positions; minimum 2.
- `PRESCALE`, 100000: clock cycles per digit slot; minimum 4.
- `GUARD`, 2: cycles at the start of each slot with all anodes off; 1 ≤ GUARD < PRESCALE.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer presents `digits_in`.
- `in_ready`  out  1  controller can accept a word.
- `digits_in`  in  4*DIGITS  packed BCD; nibble k drives digit position k (nibble 0 is the rightmost digit).
- `an`  out  DIGITS  active-low anode enables; at most one bit low at a time.
- `cur_digit`  out  4  nibble currently routed to the decoder.
- `blank`  out  1  high when `cur_digit` > 9; the decoder forces all segments off.
- `slot`  out  $clog2(DIGITS)  index of the current digit slot.
- `frame_tick`  out  1  one-cycle pulse when the slot wraps from DIGITS-1 to 0.
- `invalid_seen`  out  1  the currently committed word contains at least one nibble > 9.

## Operation
- Three registers:
  - `shadow`: 4*DIGITS bits, with a `pending` flag.
  - `active`: 4*DIGITS bits.
  - Prescale counter `pc`: counts 0..PRESCALE-1.
- Handshake:
  - `in_ready = ~pending`.
  - An accept is `in_valid & in_ready`. On accept, `shadow <= digits_in` and `pending <= 1`.
  - `digits_in` is ignored while `in_ready` is low.
- Two-state FSM per slot:
  - GAP, while `pc` < GUARD: `an` is all ones.
  - DRIVE, while `pc` ≥ GUARD: `an` = ~(1 << slot).
  - GAP moves to DRIVE when `pc` == GUARD-1. DRIVE moves to GAP when `pc` == PRESCALE-1.
- Slot advance: when `pc` == PRESCALE-1, `pc` <= 0 and `slot` <= `slot`+1, wrapping DIGITS-1 → 0. `frame_tick` is asserted that same cycle.
- Commit happens on the wrap cycle (`pc` == PRESCALE-1 and `slot` == DIGITS-1) when `pending` is 1:
  - `active <= shadow`, `pending <= 0`.
  - `invalid_seen` <= OR over all nibbles of (nibble > 9).
- Accept on the wrap cycle with `pending` == 0: the new word goes to `shadow` and is not committed this frame. It commits at the next wrap.
- `cur_digit = active[4*slot +: 4]`. `blank = (cur_digit > 4'd9)`, a 4-bit unsigned compare. Both are combinational from registered state.
- Reset values:
  - `an` all ones, `slot` 0, `pc` 0, state GAP.
  - `pending` 0, `in_ready` 1, `shadow` 0.
  - `active` all nibbles 4'hF, so `cur_digit` = 4'hF and `blank` = 1.
  - `frame_tick` 0, `invalid_seen` 1.
- Reset asserted mid-slot or mid-handshake: all state returns to the reset values on the next edge. A pending `shadow` word is discarded.

## Timing
- Accept to `in_ready` low: 1 cycle.
- Accept to first display of the new data: worst case 2 frames, best case 1 cycle after the next wrap.
- After commit, `in_ready` returns high the cycle after the wrap.
- `an` is registered. A slot change appears on `an` the cycle after `pc` wraps. GAP always precedes DRIVE, so two anodes are never low in the same cycle.
- Frame period is DIGITS*PRESCALE cycles. `frame_tick` spacing is exactly that.

## Structure
- Shared package `seg7_pkg`:
  - `BCD_MAX` = 4'd9.
  - `bcd_t` typedef (4-bit).
  - Anode-off constant.
- One sub-module, `scan_prescaler`: the `pc` counter. It outputs `slot_end` (`pc` == PRESCALE-1) and `in_gap` (`pc` < GUARD).
- The FSM, the buffers and the slot index stay in the top module.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, GUARD=2.
- Reset release, no input:
  - Required: `an`=4'b1111 for 2 cycles, then 4'b1110.
  - `blank`=1 in every slot; `invalid_seen`=1.
  - `frame_tick` every 32 cycles.
- Accept 16'h1234 during slot 1:
  - Required: `in_ready` goes low on the next cycle.
  - The next frame shows `cur_digit` 4, 3, 2, 1 in slots 0..3, with `blank`=0 and `invalid_seen`=0.
- Accept 16'h9A09:
  - Required: slot 2 has `cur_digit`=4'hA and `blank`=1; slot 3 has `cur_digit`=9 and `blank`=0; `invalid_seen`=1 after commit.
- Assert `in_valid` continuously with changing data while `pending`=1:
  - Required: only the first word is accepted, and `in_ready` stays low until the wrap.
- Accept a word exactly on the wrap cycle with `pending`=0:
  - Required: the current frame keeps the old data; the new word is committed at the following wrap.
- Assert `rst` for 1 cycle mid-DRIVE of slot 2 while `pending`=1:
  - Required: the next cycle shows `an`=4'b1111, `slot`=0, `in_ready`=1, `blank`=1, and the shadow word is never displayed.
